// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM sequencer: FSM states, APB register offsets
// and CTRL/STATUS bit positions.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [7:0] OFF_CTRL   = 8'h40;
    localparam logic [7:0] OFF_DIV    = 8'h44;
    localparam logic [7:0] OFF_STATUS = 8'h48;
    localparam logic [7:0] OFF_LEN    = 8'h4C;
    localparam logic [7:0] OFF_TABLE  = 8'h60;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_LOOP    = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_IDX_LSB = 8;

    localparam int unsigned REP_W        = 8;

endpackage

// File: rtl/pwm_seq_table.sv
// Sequence table: DEPTH entries of {repeat, compare}, APB write/read port plus
// an asynchronous read port indexed by the sequencer FSM.
module pwm_seq_table
    import pwm_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CMP_W  = 24,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [CMP_W-1:0]  rd_comp_o,
    output logic [REP_W-1:0]  rd_rep_o,
    output logic [DATA_W-1:0] apb_rdata_o,
    output logic              apb_hit_o
);

    logic [CMP_W-1:0]  comp_mem [DEPTH];
    logic [REP_W-1:0]  rep_mem  [DEPTH];
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  a_idx;

    // Addresses below the table base wrap to a large offset and miss.
    assign off       = addr_i - ADDR_W'(OFF_TABLE);
    assign a_idx     = off[IDX_W+1:2];
    assign apb_hit_o = (off[1:0] == 2'b00) && ((off >> 2) < ADDR_W'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (wr_en_i && apb_hit_o) begin
            comp_mem[a_idx] <= wdata_i[CMP_W-1:0];
            rep_mem[a_idx]  <= wdata_i[31:24];
        end
    end

    assign rd_comp_o = comp_mem[rd_idx_i];
    assign rd_rep_o  = rep_mem[rd_idx_i];

    always_comb begin
        apb_rdata_o = '0;
        if (apb_hit_o) begin
            apb_rdata_o[CMP_W-1:0] = comp_mem[a_idx];
            apb_rdata_o[31:24]     = rep_mem[a_idx];
        end
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// APB-programmed PWM duty-cycle sequencer; loads table entries into the PWM core
// at period boundaries. Define PWM_SEQ_IRQ_EN to enable the sequence-done interrupt.
module pwm_seq_ctrl
    import pwm_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CMP_W  = 24
) (
    input  logic              apb_pclk,
    input  logic              apb_prstn,
    input  logic              apb_psel,
    input  logic [ADDR_W-1:0] apb_paddr,
    input  logic              apb_pwrite,
    input  logic              apb_penable,
    input  logic [DATA_W-1:0] apb_pwdata,
    output logic [DATA_W-1:0] apb_prdata,
    input  logic              pwm_period_end,
    output logic              pwm_en,
    output logic [CMP_W-1:0]  pwm_div,
    output logic [CMP_W-1:0]  pwm_comp,
    output logic              pwm_load,
    output logic              irq
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [5:0]  DEPTH_L = 6'(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              start_q, start_d, loop_q, loop_d;
    logic              done_q, done_d, err_q, err_d;
    logic [CMP_W-1:0]  div_q, div_d, comp_q, comp_d, ldiv_q, ldiv_d;
    logic [4:0]        len_q, len_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic              wr_en, ctrl_wr, busy, len_ok, start_req, abort, irq_en_rd;
    logic [CMP_W-1:0]  tbl_comp;
    logic [REP_W-1:0]  tbl_rep;
    logic [DATA_W-1:0] tbl_rdata;
    logic              tbl_hit;

    assign wr_en   = apb_psel & apb_penable & apb_pwrite;
    assign ctrl_wr = wr_en && (apb_paddr == ADDR_W'(OFF_CTRL));
    assign busy    = (state_q != ST_IDLE);
    assign len_ok  = (len_q != 5'd0) && ({1'b0, len_q} <= DEPTH_L);

    pwm_seq_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CMP_W  (CMP_W)
    ) u_table (
        .clk_i       (apb_pclk),
        .wr_en_i     (wr_en),
        .addr_i      (apb_paddr),
        .wdata_i     (apb_pwdata),
        .rd_idx_i    (idx_q),
        .rd_comp_o   (tbl_comp),
        .rd_rep_o    (tbl_rep),
        .apb_rdata_o (tbl_rdata),
        .apb_hit_o   (tbl_hit)
    );

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rep_q    <= '0;
            start_q  <= 1'b0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            div_q    <= '0;
            comp_q   <= '0;
            ldiv_q   <= '0;
            len_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            start_q  <= start_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            err_q    <= err_d;
            div_q    <= div_d;
            comp_q   <= comp_d;
            ldiv_q   <= ldiv_d;
            len_q    <= len_d;
            prdata_q <= prdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        start_d   = start_q;
        loop_d    = loop_q;
        done_d    = done_q;
        err_d     = err_q;
        div_d     = div_q;
        comp_d    = comp_q;
        ldiv_d    = ldiv_q;
        len_d     = len_q;
        prdata_d  = prdata_q;
        start_req = ctrl_wr && apb_pwdata[CTRL_START] && !busy;
        abort     = ctrl_wr && !apb_pwdata[CTRL_START] && busy;

        if (ctrl_wr) begin
            loop_d = apb_pwdata[CTRL_LOOP];
            if (!busy) start_d = apb_pwdata[CTRL_START] && len_ok;
            else if (abort) start_d = 1'b0;
        end
        if (start_req && !len_ok) err_d = 1'b1;
        if (wr_en && (apb_paddr == ADDR_W'(OFF_DIV))) div_d = apb_pwdata[CMP_W-1:0];
        if (wr_en && (apb_paddr == ADDR_W'(OFF_STATUS))) begin
            if (apb_pwdata[STAT_DONE]) done_d = 1'b0;
            if (apb_pwdata[STAT_ERR])  err_d  = 1'b0;
        end
        if (wr_en && (apb_paddr == ADDR_W'(OFF_LEN)) && !busy) len_d = apb_pwdata[4:0];

        // Abort overrides any FSM progress in the same cycle, so DONE is never set.
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_req && len_ok) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    comp_d  = tbl_comp;
                    ldiv_d  = div_q;
                    rep_d   = (tbl_rep == '0) ? REP_W'(1) : tbl_rep;
                    state_d = ST_RUN;
                end
                ST_RUN: if (pwm_period_end) begin
                    if (rep_q > REP_W'(1)) begin
                        rep_d = rep_q - REP_W'(1);
                    end else if ((5'(idx_q) + 5'd1) < len_q) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        start_d = 1'b0;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (apb_psel && !apb_penable && !apb_pwrite) begin
            prdata_d = '0;
            if (tbl_hit) begin
                prdata_d = tbl_rdata;
            end else if (apb_paddr == ADDR_W'(OFF_CTRL)) begin
                prdata_d[CTRL_START]  = start_q;
                prdata_d[CTRL_LOOP]   = loop_q;
                prdata_d[CTRL_IRQ_EN] = irq_en_rd;
            end else if (apb_paddr == ADDR_W'(OFF_DIV)) begin
                prdata_d[CMP_W-1:0] = div_q;
            end else if (apb_paddr == ADDR_W'(OFF_STATUS)) begin
                prdata_d[STAT_BUSY]            = busy;
                prdata_d[STAT_DONE]            = done_q;
                prdata_d[STAT_ERR]             = err_q;
                prdata_d[STAT_IDX_LSB +: 4]    = 4'(idx_q);
            end else if (apb_paddr == ADDR_W'(OFF_LEN)) begin
                prdata_d[4:0] = len_q;
            end
        end
    end

`ifdef PWM_SEQ_IRQ_EN
    logic irq_en_q;
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn)   irq_en_q <= 1'b0;
        else if (ctrl_wr) irq_en_q <= apb_pwdata[CTRL_IRQ_EN];
    end
    assign irq_en_rd = irq_en_q;
    assign irq       = done_q & irq_en_q;
`else
    assign irq_en_rd = 1'b0;
    assign irq       = 1'b0;
`endif

    // LOAD presents the fresh entry directly; RUN holds the values captured in LOAD.
    assign pwm_en     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign pwm_load   = (state_q == ST_LOAD);
    assign pwm_comp   = pwm_load ? tbl_comp : comp_q;
    assign pwm_div    = pwm_load ? div_q : ldiv_q;
    assign apb_prdata = prdata_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scoreboard bench for pwm_seq_ctrl: stimulus pushes expected loads/reads,
// a negedge monitor pops and compares them.
module tb_pwm_seq_ctrl;
    import pwm_seq_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CMP_W  = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              psel = 1'b0, pwrite = 1'b0, penable = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [DATA_W-1:0] prdata;
    logic              pe = 1'b0;
    logic              pwm_en, pwm_load, irq;
    logic [CMP_W-1:0]  pwm_div, pwm_comp;

    pwm_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CMP_W  (CMP_W)
    ) dut (
        .apb_pclk       (clk),
        .apb_prstn      (rst_n),
        .apb_psel       (psel),
        .apb_paddr      (paddr),
        .apb_pwrite     (pwrite),
        .apb_penable    (penable),
        .apb_pwdata     (pwdata),
        .apb_prdata     (prdata),
        .pwm_period_end (pe),
        .pwm_en         (pwm_en),
        .pwm_div        (pwm_div),
        .pwm_comp       (pwm_comp),
        .pwm_load       (pwm_load),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [CMP_W-1:0] comp; logic [CMP_W-1:0] div; int unsigned cyc; } load_t;
    typedef struct { string name; logic [DATA_W-1:0] data; logic irq; } rd_t;

    load_t load_q[$];
    rd_t   rd_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    seq_active = 0;
    logic [CMP_W-1:0] hold_comp = '0, hold_div = '0;
    load_t mon_ld;
    rd_t   mon_rd;

    // Reference model state
    logic [CMP_W-1:0] m_comp [DEPTH];
    logic [7:0]       m_rep  [DEPTH];
    logic [CMP_W-1:0] m_div = '0;
    int               m_len = 0;
    bit               m_done = 0, m_err = 0, m_irq_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_irq();
`ifdef PWM_SEQ_IRQ_EN
        return m_done && m_irq_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] status_word(input bit busy, input bit done, input bit err, input int idx);
        logic [31:0] w;
        logic [31:0] iv;
        iv = idx;
        w = '0;
        w[0] = busy; w[1] = done; w[2] = err;
        w[11:8] = iv[3:0];
        return w;
    endfunction

    function automatic logic [31:0] ctrl_rd(input bit loop, input bit start);
        logic [31:0] w;
        w = '0;
        w[0] = start; w[1] = loop;
`ifdef PWM_SEQ_IRQ_EN
        w[2] = m_irq_en;
`endif
        return w;
    endfunction

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input string name, input logic [31:0] exp);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        rd_q.push_back('{name, exp, exp_irq()});
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_pe(input int gap);
        repeat (gap) @(posedge clk);
        #1 pe = 1'b1;
        @(posedge clk);
        #1 pe = 1'b0;
    endtask

    task automatic set_entry(input int i, input logic [CMP_W-1:0] c, input logic [7:0] r);
        m_comp[i] = c;
        m_rep[i]  = r;
        apb_write(OFF_TABLE + 8'(4 * i), {r, c});
    endtask

    // Schedule = one slot per PWM period, naming the entry it plays and whether it opens a visit.
    task automatic run_seq(input bit loop, input int abort_after, input bit rewrite);
        int sidx[$];
        bit snew[$];
        int passes, total, r;
        passes = loop ? 3 : 1;
        for (int ps = 0; ps < passes; ps++)
            for (int i = 0; i < m_len; i++) begin
                r = (m_rep[i] == 0) ? 1 : int'(m_rep[i]);
                for (int k = 0; k < r; k++) begin
                    sidx.push_back(i);
                    snew.push_back(k == 0);
                end
            end
        apb_write(OFF_CTRL, {29'd0, m_irq_en, loop, 1'b1});
        load_q.push_back('{m_comp[0], m_div, cyc});
        seq_active = 1;
        total = (abort_after > 0) ? abort_after : sidx.size();
        for (int p = 0; p < total; p++) begin
            if (rewrite && p == 0) begin
                set_entry(0, 24'd5, m_rep[0]);
                apb_write(OFF_DIV, 32'd12);
                m_div = 24'd12;
                apb_write(OFF_LEN, 32'd5);
            end
            pulse_pe(int'($urandom_range(1, 4)));
            if (p + 1 < sidx.size() && snew[p + 1])
                load_q.push_back('{m_comp[sidx[p + 1]], m_div, cyc});
        end
        if (abort_after > 0) begin
            apb_write(OFF_CTRL, {29'd0, m_irq_en, 2'b00});
            seq_active = 0;
            apb_read(OFF_STATUS, "status_abort", status_word(0, m_done, m_err, sidx[total]));
            apb_read(OFF_CTRL, "ctrl_abort", ctrl_rd(0, 0));
        end else begin
            seq_active = 0;
            m_done = 1;
            apb_read(OFF_STATUS, "status_done", status_word(0, 1, m_err, m_len - 1));
            apb_read(OFF_CTRL, "ctrl_done", ctrl_rd(loop, 0));
        end
        chk("loads_pending", load_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pwm_load) begin
                if (load_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got comp %h expected no load", pwm_comp);
                end else begin
                    mon_ld = load_q.pop_front();
                    chk("load_comp", 32'(pwm_comp), 32'(mon_ld.comp));
                    chk("load_div", 32'(pwm_div), 32'(mon_ld.div));
                    chk("load_cycle", cyc, mon_ld.cyc);
                    hold_comp = mon_ld.comp;
                    hold_div  = mon_ld.div;
                end
            end else if (pwm_en) begin
                chk("held_comp", 32'(pwm_comp), 32'(hold_comp));
                chk("held_div", 32'(pwm_div), 32'(hold_div));
            end
            chk("pwm_en", 32'(pwm_en), 32'(seq_active));
            if (psel && penable && !pwrite) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %h expected no read", prdata);
                end else begin
                    mon_rd = rd_q.pop_front();
                    chk(mon_rd.name, prdata, mon_rd.data);
                    chk({mon_rd.name, "_irq"}, 32'(irq), 32'(mon_rd.irq));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic directed_setup();
        apb_write(OFF_DIV, 32'd10);
        m_div = 24'd10;
        apb_write(OFF_LEN, 32'd2);
        m_len = 2;
        set_entry(0, 24'd3, 8'd2);
        set_entry(1, 24'd7, 8'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_pwm_en", 32'(pwm_en), 0);
        chk("rst_pwm_load", 32'(pwm_load), 0);
        chk("rst_pwm_comp", 32'(pwm_comp), 0);
        chk("rst_pwm_div", 32'(pwm_div), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_prdata", prdata, 0);
        apb_read(OFF_STATUS, "status_rst", 32'd0);

        // Basic two-entry sequence
        m_irq_en = 1;
        directed_setup();
        run_seq(0, 0, 0);
        pulse_pe(2);
        apb_read(OFF_TABLE + 8'd4, "table1", {8'd1, 24'd7});
        apb_write(OFF_STATUS, 32'h2);
        m_done = 0;
        apb_read(OFF_STATUS, "status_w1c_done", status_word(0, 0, 0, 1));

        // Illegal lengths
        apb_write(OFF_LEN, 32'd0);
        m_len = 0;
        apb_write(OFF_CTRL, {29'd0, m_irq_en, 2'b01});
        m_err = 1;
        apb_read(OFF_STATUS, "status_err_len0", status_word(0, 0, 1, 1));
        apb_read(OFF_CTRL, "ctrl_err", ctrl_rd(0, 0));
        apb_write(OFF_STATUS, 32'h4);
        m_err = 0;
        apb_read(OFF_STATUS, "status_w1c_err", status_word(0, 0, 0, 1));
        apb_write(OFF_LEN, 32'd9);
        m_len = 9;
        apb_write(OFF_CTRL, {29'd0, m_irq_en, 2'b01});
        m_err = 1;
        apb_read(OFF_STATUS, "status_err_len9", status_word(0, 0, 1, 1));
        apb_write(OFF_STATUS, 32'h4);
        m_err = 0;

        // Looping sequence, then aborted
        directed_setup();
        run_seq(1, 5, 0);

        // Table/DIV/LEN writes while running
        directed_setup();
        run_seq(1, 4, 1);
        apb_read(OFF_LEN, "len_busy_ignored", 32'd2);
        apb_read(OFF_TABLE, "table0_rewritten", {8'd2, 24'd5});

        // Randomized sequences
        for (int it = 0; it < 5; it++) begin
            m_irq_en = $urandom_range(0, 1);
            m_div = CMP_W'($urandom);
            apb_write(OFF_DIV, 32'(m_div));
            m_len = $urandom_range(1, DEPTH);
            apb_write(OFF_LEN, 32'(m_len));
            for (int i = 0; i < m_len; i++)
                set_entry(i, CMP_W'($urandom), 8'($urandom_range(0, 3)));
            run_seq(0, 0, 0);
            apb_read(OFF_DIV, "div_rb", 32'(m_div));
            apb_write(OFF_STATUS, 32'h2);
            m_done = 0;
            apb_read(OFF_STATUS, "status_rand_clr", status_word(0, 0, 0, m_len - 1));
        end

        apb_read(8'h50, "unmapped_50", 32'd0);
        apb_read(8'h00, "unmapped_00", 32'd0);

        // Reset in the middle of a sequence
        apb_write(OFF_CTRL, {29'd0, m_irq_en, 2'b01});
        load_q.push_back('{m_comp[0], m_div, cyc});
        seq_active = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        seq_active = 0;
        #1;
        chk("midrst_pwm_en", 32'(pwm_en), 0);
        chk("midrst_pwm_load", 32'(pwm_load), 0);
        chk("midrst_pwm_comp", 32'(pwm_comp), 0);
        chk("midrst_pwm_div", 32'(pwm_div), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_done = 0; m_err = 0; m_len = 0; m_div = '0; m_irq_en = 0;
        apb_read(OFF_STATUS, "status_midrst", 32'd0);
        apb_read(OFF_LEN, "len_midrst", 32'd0);
        apb_read(OFF_DIV, "div_midrst", 32'd0);
        chk("loads_final", load_q.size(), 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
